bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/mul10_add.sv | 19 +
 rtl/bcd_to_bin.sv | 120 ++++++++++++
 tb/tb_bcd_to_bin.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: default sizes, the FSM
// state encoding and the digit-select width helper.
package bcd_pkg;

    localparam int NDIG_DEF = 4;
    localparam int BW_DEF   = 14;
    localparam int DIG_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that selects one of ndig digits (at least one bit).
    function automatic int sel_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational acc*10 + digit at BW bits, with an invalid-digit flag.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int BW = BW_DEF
) (
    input  logic [BW-1:0]    acc,
    input  logic [DIG_W-1:0] digit,
    output logic [BW-1:0]    result,
    output logic             bad_digit
);

    // Shift-and-add multiply by ten; any carry beyond BW bits is dropped.
    always_comb begin
        result    = (acc << 3) + (acc << 1) + BW'(digit);
        bad_digit = (digit > 4'd9);
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int BW   = BW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIG_W*NDIG-1:0] bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [BW-1:0]         bin_out,
    output logic                  err
);

    localparam int CW = sel_width(NDIG);

    state_t                  state_q, state_d;
    logic [DIG_W*NDIG-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]           acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    errf_q, errf_d;
    logic [BW-1:0]           bin_q, bin_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic [DIG_W-1:0]        digit;
    logic [BW-1:0]           mul_res;
    logic                    dig_bad;

    // Select the digit addressed by the down-counter.
    always_comb begin
        digit = bcd_q[DIG_W*cnt_q +: DIG_W];
    end

    mul10_add #(
        .BW(BW)
    ) u_mul10_add (
        .acc      (acc_q),
        .digit    (digit),
        .result   (mul_res),
        .bad_digit(dig_bad)
    );

    // Next-state and datapath updates for IDLE -> CONV -> DONE.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        errf_d  = errf_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    acc_d   = '0;
                    errf_d  = 1'b0;
                    cnt_d   = CW'(NDIG - 1);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d  = mul_res;
                errf_d = errf_q | dig_bad;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bin_d   = errf_q ? '0 : acc_q;
                err_d   = errf_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            errf_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            errf_q  <= errf_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Status decode and registered result outputs.
    always_comb begin
        ready   = (state_q == ST_IDLE);
        busy    = (state_q == ST_CONV);
        done    = done_q;
        bin_out = bin_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and random checks for bcd_to_bin with NDIG=4, BW=14.
module tb_bcd_to_bin;

    localparam int NDIG = 4;
    localparam int BW   = 14;
    localparam int LAT  = NDIG + 1;   // negedges after the first post-accept sample

    logic            clk;
    logic            rst;
    logic            start;
    logic [15:0]     bcd_in;
    logic            ready;
    logic            busy;
    logic            done;
    logic [BW-1:0]   bin_out;
    logic            err;

    int checks;
    int errors;

    bcd_to_bin #(
        .NDIG(NDIG),
        .BW  (BW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd_in (bcd_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge after the accepting edge.
    task automatic pulse_start(input logic [15:0] v);
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Wait (bounded) for done; cyc = negedges waited, -1 on timeout.
    task automatic wait_done(output int cyc, output int busy_cnt);
        busy_cnt = busy ? 1 : 0;
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL reset_bin got=%0d exp=0", bin_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_zero();
        int cyc, bc;
        pulse_start(16'h0000);
        wait_done(cyc, bc);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL zero_bin got=%0d exp=0", bin_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err got=%b exp=0", err); end
    endtask

    task automatic test_max();
        int cyc, bc;
        pulse_start(16'h9999);
        wait_done(cyc, bc);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL max_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bin_out !== 14'h270F) begin errors++; $display("FAIL max_bin got=%0d exp=9999", bin_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL max_err got=%b exp=0", err); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL max_busy_cycles got=%0d exp=4", bc); end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, extra;
        pulse_start(16'h0042);
        bcd_in = 16'h1111;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(cyc, bc);
        checks++; if (cyc !== LAT - 1) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", cyc, LAT - 1); end
        checks++; if (bin_out !== 14'd42) begin errors++; $display("FAIL ignore_bin got=%0d exp=42", bin_out); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
        checks++; if (bin_out !== 14'd42) begin errors++; $display("FAIL ignore_hold got=%0d exp=42", bin_out); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ignore_ready got=%b exp=1", ready); end
    endtask

    task automatic test_bad_digit();
        int cyc, bc;
        pulse_start(16'h12A4);
        wait_done(cyc, bc);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL bad_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", err); end
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL bad_bin got=%0d exp=0", bin_out); end
        pulse_start(16'h0063);
        wait_done(cyc, bc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL recover_err got=%b exp=0", err); end
        checks++; if (bin_out !== 14'd63) begin errors++; $display("FAIL recover_bin got=%0d exp=63", bin_out); end
    endtask

    task automatic test_abort();
        int cyc, bc, extra;
        pulse_start(16'h5555);
        @(negedge clk);        // now in the second CONV cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL abort_bin got=%0d exp=0", bin_out); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", extra); end
        pulse_start(16'h0007);
        wait_done(cyc, bc);
        checks++; if (cyc !== LAT) begin errors++; $display("FAIL after_abort_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bin_out !== 14'd7) begin errors++; $display("FAIL after_abort_bin got=%0d exp=7", bin_out); end
    endtask

    task automatic test_rst_over_start();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; bcd_in = 16'h0123;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_start_ready got=%b exp=1", ready); end
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL rst_start_bin got=%0d exp=0", bin_out); end
    endtask

    task automatic test_random();
        int cyc, bc, val;
        logic [15:0] v;
        for (int n = 0; n < 1000; n++) begin
            val = 0;
            for (int d = NDIG - 1; d >= 0; d--) begin
                int dg;
                dg = $urandom_range(9, 0);
                v[4*d +: 4] = 4'(dg);
                val = val * 10 + dg;
            end
            pulse_start(v);
            wait_done(cyc, bc);
            checks++; if (cyc !== LAT) begin errors++; $display("FAIL rand_latency in=%h got=%0d exp=%0d", v, cyc, LAT); end
            checks++; if (int'(bin_out) !== val) begin errors++; $display("FAIL rand_bin in=%h got=%0d exp=%0d", v, bin_out, val); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err in=%h got=%b exp=0", v, err); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero();
        test_max();
        test_ignore_start();
        test_bad_digit();
        test_abort();
        test_rst_over_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
